ccip_if_retimer: RTL and testbench
==================================

// Module: ccip_if_retimer
// PURPOSE
//  Parametrised register-retiming shell between the FIU (SR) and AFU (PR) on pClk.
//  Pipelines NUM_RX Rx and NUM_TX Tx valid/payload channels and the Tx almost-full flags.
//  Also produces a stretched AFU soft reset, a registered power state and a sticky error flag.
//  Also keeps per-Rx-channel saturating beat counters.
//  Instantiated in ccip_std_afu in place of the fixed single-stage input registers.
// PARAMETERS
//  NUM_RX     2    Rx channels (FIU->AFU)
//  NUM_TX     3    Tx channels (AFU->FIU); also number of almost-full flags
//  RX_W       552  payload bits per Rx channel
//  TX_W       614  payload bits per Tx channel
//  RX_STAGES  1    Rx/almfull/softReset/pwrState/error pipeline depth (>=1)
//  TX_STAGES  1    Tx pipeline depth (>=1)
//  RST_HOLD   16   extra cycles afu_softReset stays high after pipelined softReset falls (0 = none)
//  CNT_W      32   Rx beat counter width
// PORTS
//  pClk               in   1            400MHz CCI-P clock; sole clock
//  pClk_rst_n         in   1            async assert, active-low; deassert synchronous to pClk upstream
//  cp2af_softReset    in   1            FIU soft reset, sync, active-high
//  cp2af_pwrState     in   2            FIU power state
//  cp2af_error        in   1            FIU protocol error pulse/level
//  error_clr          in   1            clears error_sticky
//  rx_valid_in        in   NUM_RX       Rx valids from FIU
//  rx_data_in         in   NUM_RX*RX_W  Rx payloads; channel i at [i*RX_W +: RX_W]
//  almfull_in         in   NUM_TX       Tx almost-full flags from FIU
//  tx_valid_in        in   NUM_TX       Tx valids from AFU
//  tx_data_in         in   NUM_TX*TX_W  Tx payloads from AFU
//  rx_valid_out       out  NUM_RX       Rx valids to AFU
//  rx_data_out        out  NUM_RX*RX_W  Rx payloads to AFU
//  almfull_out        out  NUM_TX       almost-full flags to AFU
//  tx_valid_out       out  NUM_TX       Tx valids to FIU
//  tx_data_out        out  NUM_TX*TX_W  Tx payloads to FIU
//  afu_softReset      out  1            stretched soft reset to AFU
//  pwrState_out       out  2            pipelined power state
//  error_sticky       out  1            sticky protocol error
//  rx_beat_cnt        out  NUM_RX*CNT_W per-channel Rx beat counters
// BEHAVIOUR
//  Async reset (pClk_rst_n=0) values:
//   - all valid stages = 0; almfull stages = all ones; afu_softReset = 1
//   - stretch counter = RST_HOLD; pwrState_out = 0; error_sticky = 0; counters = 0
//   - payload stages not reset (don't-care while valid=0)
//  Rx path: rx_valid/data_out = rx_valid/data_in delayed exactly RX_STAGES cycles.
//   Valid bits are forced 0 while afu_softReset=1.
//  almfull_out = almfull_in delayed RX_STAGES; forced all ones while afu_softReset=1.
//  Tx path: tx_valid/data_out = tx_valid/data_in delayed TX_STAGES cycles.
//   Valid is forced 0 at the output stage while afu_softReset=1.
//   No flow control inside block; AFU honours almfull_out with CCI-P in-flight allowance.
//  Soft reset:
//   - sr_p = cp2af_softReset delayed RX_STAGES; afu_softReset = sr_p | (cnt!=0)
//   - while sr_p=1: cnt loads RST_HOLD
//   - while sr_p=0 and cnt!=0: cnt decrements
//   - result: afu_softReset falls exactly RST_HOLD cycles after sr_p falls
//   - sr_p reasserting mid-count reloads cnt; afu_softReset never glitches low
//  pwrState_out = cp2af_pwrState delayed RX_STAGES.
//  error_sticky:
//   - set the cycle after pipelined error=1; cleared the cycle after error_clr=1
//   - set wins over simultaneous clr; unaffected by soft reset
//  rx_beat_cnt[i]: +1 per cycle rx_valid_out[i]=1; saturates at 2^CNT_W-1 (no wrap)
//   - cleared (held 0) while afu_softReset=1
// TESTING
//  - Reset: rst_n=0 mid-traffic -> all valids 0, almfull_out all 1, afu_softReset 1 within same cycle.
//  - Latency, RX_STAGES=3, TX_STAGES=2: rx_valid_in[1] pulse at t=10, data 0xA5 -> rx_valid_out[1] at t=13 with 0xA5;
//    tx_valid_in[2] at t=10 -> tx_valid_out[2] at t=12.
//  - Stretch, RST_HOLD=16: softReset falls at t=20 -> afu_softReset falls at t=20+RX_STAGES+16;
//    re-pulse at +5 -> count restarts from the pulse's falling edge.
//  - Gating: tx_valid_in=3'b111 held during afu_softReset=1 -> tx_valid_out=0; almfull_out=3'b111.
//  - Error: error=1 one cycle, then clr=1 and error=1 same cycle -> sticky stays 1; clr alone -> 0 next cycle.
//  - Counter, CNT_W=4: 20 consecutive rx valids -> rx_beat_cnt saturates at 15; softReset -> 0.

Source files
------------

// File: rtl/ccip_if_retimer.sv
// ccip_if_retimer
//   Register-retiming shell between the FIU and the AFU, clocked on pClk.
//   Rx valid/payload, Tx almost-full flags, soft reset, power state and the
//   error pulse are delayed RX_STAGES cycles. Tx valid/payload are delayed
//   TX_STAGES cycles. The AFU soft reset is stretched by RST_HOLD cycles and
//   gates every outgoing valid. Almost-full flags are forced high while it is
//   asserted. A sticky error flag and per-Rx-channel saturating beat counters
//   are also kept.
// Ports
//   pClk, pClk_rst_n         : clock, async active-low reset
//   cp2af_softReset/pwrState : FIU soft reset and power state
//   cp2af_error, error_clr   : error pulse in, sticky clear
//   rx_valid_in/rx_data_in   : FIU->AFU channels (channel i at [i*RX_W +: RX_W])
//   almfull_in               : Tx almost-full flags from FIU
//   tx_valid_in/tx_data_in   : AFU->FIU channels (channel i at [i*TX_W +: TX_W])
//   *_out, afu_softReset     : retimed / gated versions toward AFU or FIU
//   error_sticky             : latched error
//   rx_beat_cnt              : per-Rx-channel beat counters (CNT_W each)

// Generic delay line. Payload lines skip reset (HAS_RST=0) so they stay plain flops.
module ccip_if_retimer_pipe #(
  parameter int           W       = 1,
  parameter int           STAGES  = 1,
  parameter bit           HAS_RST = 1'b1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         pClk,
  input  logic         pClk_rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [STAGES-1:0][W-1:0] stg;

  generate
    if (HAS_RST) begin : g_rst
      always_ff @(posedge pClk or negedge pClk_rst_n) begin
        if (!pClk_rst_n) begin
          stg <= {STAGES{RST_VAL}};
        end else begin
          stg[0] <= d;
          for (int s = 1; s < STAGES; s++) stg[s] <= stg[s-1];
        end
      end
    end else begin : g_nrst
      logic unusedRst;
      assign unusedRst = pClk_rst_n;
      always_ff @(posedge pClk) begin
        stg[0] <= d;
        for (int s = 1; s < STAGES; s++) stg[s] <= stg[s-1];
      end
    end
  endgenerate

  assign q = stg[STAGES-1];
endmodule

module ccip_if_retimer #(
  parameter int NUM_RX    = 2,
  parameter int NUM_TX    = 3,
  parameter int RX_W      = 552,
  parameter int TX_W      = 614,
  parameter int RX_STAGES = 1,
  parameter int TX_STAGES = 1,
  parameter int RST_HOLD  = 16,
  parameter int CNT_W     = 32
) (
  input  logic                    pClk,
  input  logic                    pClk_rst_n,
  input  logic                    cp2af_softReset,
  input  logic [1:0]              cp2af_pwrState,
  input  logic                    cp2af_error,
  input  logic                    error_clr,
  input  logic [NUM_RX-1:0]       rx_valid_in,
  input  logic [NUM_RX*RX_W-1:0]  rx_data_in,
  input  logic [NUM_TX-1:0]       almfull_in,
  input  logic [NUM_TX-1:0]       tx_valid_in,
  input  logic [NUM_TX*TX_W-1:0]  tx_data_in,
  output logic [NUM_RX-1:0]       rx_valid_out,
  output logic [NUM_RX*RX_W-1:0]  rx_data_out,
  output logic [NUM_TX-1:0]       almfull_out,
  output logic [NUM_TX-1:0]       tx_valid_out,
  output logic [NUM_TX*TX_W-1:0]  tx_data_out,
  output logic                    afu_softReset,
  output logic [1:0]              pwrState_out,
  output logic                    error_sticky,
  output logic [NUM_RX*CNT_W-1:0] rx_beat_cnt
);
  localparam int HOLD_W = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;

  logic              srP, errP;
  logic [HOLD_W-1:0] holdCnt;

  // Soft reset pipe resets high so afu_softReset is asserted out of reset even with RST_HOLD=0.
  ccip_if_retimer_pipe #(.W(1), .STAGES(RX_STAGES), .HAS_RST(1'b1), .RST_VAL(1'b1)) uSrPipe (
    .pClk(pClk), .pClk_rst_n(pClk_rst_n), .d(cp2af_softReset), .q(srP));
  ccip_if_retimer_pipe #(.W(2), .STAGES(RX_STAGES), .HAS_RST(1'b1), .RST_VAL(2'b00)) uPwrPipe (
    .pClk(pClk), .pClk_rst_n(pClk_rst_n), .d(cp2af_pwrState), .q(pwrState_out));
  ccip_if_retimer_pipe #(.W(1), .STAGES(RX_STAGES), .HAS_RST(1'b1), .RST_VAL(1'b0)) uErrPipe (
    .pClk(pClk), .pClk_rst_n(pClk_rst_n), .d(cp2af_error), .q(errP));

  // Reload while the pipelined reset is high, so a re-pulse restarts the
  // stretch from its own falling edge and the output never dips low.
  always_ff @(posedge pClk or negedge pClk_rst_n) begin
    if (!pClk_rst_n)         holdCnt <= HOLD_W'(RST_HOLD);
    else if (srP)            holdCnt <= HOLD_W'(RST_HOLD);
    else if (holdCnt != '0)  holdCnt <= holdCnt - 1'b1;
  end

  assign afu_softReset = srP | (holdCnt != '0);

  // Set has priority over clear; soft reset does not touch it.
  always_ff @(posedge pClk or negedge pClk_rst_n) begin
    if (!pClk_rst_n)    error_sticky <= 1'b0;
    else if (errP)      error_sticky <= 1'b1;
    else if (error_clr) error_sticky <= 1'b0;
  end

  generate
    for (genvar i = 0; i < NUM_RX; i++) begin : g_rx
      logic             vQ;
      logic [CNT_W-1:0] beatCnt;

      ccip_if_retimer_pipe #(.W(1), .STAGES(RX_STAGES), .HAS_RST(1'b1), .RST_VAL(1'b0)) uVld (
        .pClk(pClk), .pClk_rst_n(pClk_rst_n), .d(rx_valid_in[i]), .q(vQ));
      ccip_if_retimer_pipe #(.W(RX_W), .STAGES(RX_STAGES), .HAS_RST(1'b0)) uDat (
        .pClk(pClk), .pClk_rst_n(pClk_rst_n), .d(rx_data_in[i*RX_W +: RX_W]),
        .q(rx_data_out[i*RX_W +: RX_W]));

      assign rx_valid_out[i] = vQ & ~afu_softReset;

      always_ff @(posedge pClk or negedge pClk_rst_n) begin
        if (!pClk_rst_n)                          beatCnt <= '0;
        else if (afu_softReset)                   beatCnt <= '0;
        else if (rx_valid_out[i] && beatCnt != '1) beatCnt <= beatCnt + 1'b1;
      end

      assign rx_beat_cnt[i*CNT_W +: CNT_W] = beatCnt;
    end

    for (genvar j = 0; j < NUM_TX; j++) begin : g_tx
      logic vQ, afQ;

      ccip_if_retimer_pipe #(.W(1), .STAGES(TX_STAGES), .HAS_RST(1'b1), .RST_VAL(1'b0)) uVld (
        .pClk(pClk), .pClk_rst_n(pClk_rst_n), .d(tx_valid_in[j]), .q(vQ));
      ccip_if_retimer_pipe #(.W(TX_W), .STAGES(TX_STAGES), .HAS_RST(1'b0)) uDat (
        .pClk(pClk), .pClk_rst_n(pClk_rst_n), .d(tx_data_in[j*TX_W +: TX_W]),
        .q(tx_data_out[j*TX_W +: TX_W]));
      // Almost-full travels with the Rx timing and idles high.
      ccip_if_retimer_pipe #(.W(1), .STAGES(RX_STAGES), .HAS_RST(1'b1), .RST_VAL(1'b1)) uAf (
        .pClk(pClk), .pClk_rst_n(pClk_rst_n), .d(almfull_in[j]), .q(afQ));

      assign tx_valid_out[j] = vQ & ~afu_softReset;
      assign almfull_out[j]  = afQ | afu_softReset;
    end
  endgenerate
endmodule

// File: tb/tb_ccip_if_retimer.sv
module tb_ccip_if_retimer;
  localparam int NRX = 2, NTX = 3, RXW = 64, TXW = 72;
  localparam int RS = 3, TS = 2, HOLD = 16, CW = 4;
  localparam int NCYC = 400, MAXC = 512;

  logic                pClk = 1'b0, pClk_rst_n = 1'b0;
  logic                cp2af_softReset = 1'b0, cp2af_error = 1'b0, error_clr = 1'b0;
  logic [1:0]          cp2af_pwrState = '0;
  logic [NRX-1:0]      rx_valid_in = '0;
  logic [NRX*RXW-1:0]  rx_data_in = '0;
  logic [NTX-1:0]      almfull_in = '0, tx_valid_in = '0;
  logic [NTX*TXW-1:0]  tx_data_in = '0;
  logic [NRX-1:0]      rx_valid_out;
  logic [NRX*RXW-1:0]  rx_data_out;
  logic [NTX-1:0]      almfull_out, tx_valid_out;
  logic [NTX*TXW-1:0]  tx_data_out;
  logic                afu_softReset, error_sticky;
  logic [1:0]          pwrState_out;
  logic [NRX*CW-1:0]   rx_beat_cnt;

  ccip_if_retimer #(.NUM_RX(NRX), .NUM_TX(NTX), .RX_W(RXW), .TX_W(TXW), .RX_STAGES(RS),
                    .TX_STAGES(TS), .RST_HOLD(HOLD), .CNT_W(CW)) dut (
    .pClk(pClk), .pClk_rst_n(pClk_rst_n), .cp2af_softReset(cp2af_softReset),
    .cp2af_pwrState(cp2af_pwrState), .cp2af_error(cp2af_error), .error_clr(error_clr),
    .rx_valid_in(rx_valid_in), .rx_data_in(rx_data_in), .almfull_in(almfull_in),
    .tx_valid_in(tx_valid_in), .tx_data_in(tx_data_in), .rx_valid_out(rx_valid_out),
    .rx_data_out(rx_data_out), .almfull_out(almfull_out), .tx_valid_out(tx_valid_out),
    .tx_data_out(tx_data_out), .afu_softReset(afu_softReset), .pwrState_out(pwrState_out),
    .error_sticky(error_sticky), .rx_beat_cnt(rx_beat_cnt));

  always #5 pClk = ~pClk;

  // Input history, one entry per cycle (inputs are applied just after the rising edge).
  bit                 rstH[MAXC], srH[MAXC], errH[MAXC], clrH[MAXC];
  logic [1:0]         pwrH[MAXC];
  logic [NRX-1:0]     rxVH[MAXC];
  logic [NRX*RXW-1:0] rxDH[MAXC];
  logic [NTX-1:0]     afH[MAXC], txVH[MAXC];
  logic [NTX*TXW-1:0] txDH[MAXC];
  // Expected-output history needed by the stateful parts of the model.
  bit                 afuE[MAXC], stickyE[MAXC];
  logic [NRX-1:0]     rxVoE[MAXC];
  logic [NRX*CW-1:0]  cntE[MAXC];

  int nChk = 0, nFail = 0, cyc = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    nChk++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Any reset seen in cycles lo..hi wipes a value still in flight; pre-history counts as reset.
  function automatic bit rstWin(int lo, int hi);
    for (int k = lo; k <= hi; k++) if (k < 0 || rstH[k]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit srP(int m);
    if (rstWin(m - RS, m)) return 1'b1;
    return srH[m - RS];
  endfunction

  function automatic bit errP(int m);
    if (rstWin(m - RS, m)) return 1'b0;
    return errH[m - RS];
  endfunction

  // AFU reset is high whenever the delayed soft reset was high within the last HOLD cycles.
  function automatic bit afuRef(int n);
    for (int m = n - HOLD; m <= n; m++) if (srP(m)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive(input int n);
    bit r, s, e, c;
    logic [NRX-1:0] rv;
    logic [NTX-1:0] tv;
    r = (n < 4) || (n >= 200 && n < 202);
    s = (n >= 4 && n < 20) || n == 25 || (n >= 130 && n < 150) || (n >= 300 && n < 303);
    rv = NRX'($urandom_range(0, 3));
    if (n >= 60 && n < 90) rv = '1;
    tv = NTX'($urandom_range(0, 7));
    if (n >= 130 && n < 150) tv = '1;
    if (n >= 95 && n <= 110) begin
      e = (n == 100 || n == 101);
      c = (n == 104 || n == 107);
    end else begin
      e = ($urandom_range(0, 15) == 0);
      c = ($urandom_range(0, 7) == 0);
    end
    for (int i = 0; i < NRX; i++) rx_data_in[i*RXW +: RXW] = RXW'({$urandom, $urandom, $urandom});
    for (int j = 0; j < NTX; j++) tx_data_in[j*TXW +: TXW] = TXW'({$urandom, $urandom, $urandom});
    if (n == 50) begin
      rv = 2'b10;
      rx_data_in[RXW +: RXW] = RXW'(8'hA5);
    end
    pClk_rst_n      = ~r;
    cp2af_softReset = s;
    cp2af_error     = e;
    error_clr       = c;
    cp2af_pwrState  = 2'($urandom_range(0, 3));
    rx_valid_in     = rv;
    tx_valid_in     = tv;
    almfull_in      = NTX'($urandom_range(0, 7));
    rstH[n] = r; srH[n] = s; errH[n] = e; clrH[n] = c; pwrH[n] = cp2af_pwrState;
    rxVH[n] = rv; rxDH[n] = rx_data_in; afH[n] = almfull_in; txVH[n] = tv; txDH[n] = tx_data_in;
  endtask

  task automatic checkCycle(input int n);
    bit a, rw, tw;
    logic [NRX-1:0] eRxV;
    logic [NTX-1:0] eAf, eTxV;
    logic [1:0]     ePwr;
    logic [CW-1:0]  prev;
    a  = afuRef(n);
    rw = rstWin(n - RS, n);
    tw = rstWin(n - TS, n);
    eRxV = '0; eAf = '1; eTxV = '0; ePwr = '0;
    if (!rw) begin
      eRxV = rxVH[n-RS] & ~{NRX{a}};
      eAf  = afH[n-RS] | {NTX{a}};
      ePwr = pwrH[n-RS];
    end
    if (!tw) eTxV = txVH[n-TS] & ~{NTX{a}};
    afuE[n]  = a;
    rxVoE[n] = eRxV;
    if (rstWin(n - 1, n))  stickyE[n] = 1'b0;
    else if (errP(n - 1))  stickyE[n] = 1'b1;
    else if (clrH[n - 1])  stickyE[n] = 1'b0;
    else                   stickyE[n] = stickyE[n - 1];
    for (int i = 0; i < NRX; i++) begin
      if (rstWin(n - 1, n) || afuE[n - 1]) cntE[n][i*CW +: CW] = '0;
      else begin
        prev = cntE[n - 1][i*CW +: CW];
        cntE[n][i*CW +: CW] = (rxVoE[n - 1][i] && prev != {CW{1'b1}}) ? prev + 1'b1 : prev;
      end
    end
    chk("afu_softReset", 256'(afu_softReset), 256'(a));
    chk("rx_valid",      256'(rx_valid_out),  256'(eRxV));
    chk("almfull",       256'(almfull_out),   256'(eAf));
    chk("tx_valid",      256'(tx_valid_out),  256'(eTxV));
    chk("pwrState",      256'(pwrState_out),  256'(ePwr));
    chk("error_sticky",  256'(error_sticky),  256'(stickyE[n]));
    chk("beat_cnt",      256'(rx_beat_cnt),   256'(cntE[n]));
    for (int i = 0; i < NRX; i++)
      if (eRxV[i]) chk("rx_data", 256'(rx_data_out[i*RXW +: RXW]), 256'(rxDH[n-RS][i*RXW +: RXW]));
    for (int j = 0; j < NTX; j++)
      if (eTxV[j]) chk("tx_data", 256'(tx_data_out[j*TXW +: TXW]), 256'(txDH[n-TS][j*TXW +: TXW]));
  endtask

  initial begin
    for (int n = 0; n < NCYC; n++) begin
      @(posedge pClk);
      #1;
      cyc = n;
      drive(n);
      @(negedge pClk);
      checkCycle(n);
    end
    $display("[TB] %0d tests run, %0d failed", nChk, nFail);
    $finish;
  end
endmodule
